// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding/flush/halt controller with a per-stage destination scoreboard.
// Optional perf counters (stall_cnt, flush_cnt) when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW     = 4,
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned LOAD_STAGE = 1,
    parameter int unsigned FW_W       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic              id_rs_used,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic              id_rt_used,
    input  logic              id_we_rf,
    input  logic [REG_AW-1:0] id_dst_addr,
    input  logic              id_is_load,
    input  logic              id_is_hlt,
    input  logic              jmp_taken,
    input  logic              br_taken,
    input  logic              mem_busy,
`ifdef HAZ_PERF_CNT_EN
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt,
`endif
    output logic              stall_if_id,
    output logic              bubble_id_ex,
    output logic              flush_if_id,
    output logic              freeze,
    output logic [FW_W-1:0]   fwd_a,
    output logic [FW_W-1:0]   fwd_b,
    output logic              hlt
);

    localparam int unsigned CW = $clog2(NUM_STAGES + 1);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_STAGES-1:0]   sb_valid_q, sb_we_q, sb_load_q;
    logic [REG_AW-1:0]       sb_dst_q [NUM_STAGES];
    logic [REG_AW-1:0]       ex_rs_q, ex_rt_q;
    logic                    ex_rs_used_q, ex_rt_used_q;

    logic                    freeze_c, load_use, lu_stall, id_adv;
    logic [FW_W-1:0]         fwd_a_c, fwd_b_c;

    assign freeze_c = mem_busy | (state_q == StHalted);
    assign freeze   = ~rst & freeze_c;
    assign hlt      = ~rst & (state_q == StHalted);

    // Only loads still short of LOAD_STAGE have no forwardable data yet.
    always_comb begin
        load_use = 1'b0;
        for (int unsigned s = 0; s < LOAD_STAGE; s++) begin
            if (s < NUM_STAGES && sb_valid_q[s] && sb_we_q[s] && sb_load_q[s]) begin
                if (id_rs_used && id_rs_addr != '0 && id_rs_addr == sb_dst_q[s]) load_use = 1'b1;
                if (id_rt_used && id_rt_addr != '0 && id_rt_addr == sb_dst_q[s]) load_use = 1'b1;
            end
        end
        load_use = load_use & id_valid;
    end

    // Scan oldest to youngest so the youngest match overrides.
    always_comb begin
        fwd_a_c = '0;
        fwd_b_c = '0;
        for (int s = int'(NUM_STAGES) - 1; s >= 1; s--) begin
            if (sb_valid_q[s] && sb_we_q[s]) begin
                if (ex_rs_used_q && ex_rs_q != '0 && ex_rs_q == sb_dst_q[s]) fwd_a_c = FW_W'(s);
                if (ex_rt_used_q && ex_rt_q != '0 && ex_rt_q == sb_dst_q[s]) fwd_b_c = FW_W'(s);
            end
        end
    end

    assign fwd_a = rst ? '0 : fwd_a_c;
    assign fwd_b = rst ? '0 : fwd_b_c;

    always_comb begin
        stall_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        lu_stall     = 1'b0;
        if (!rst && !freeze_c) begin
            if (state_q == StDrain) begin
                stall_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end else if (br_taken) begin
                flush_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end else if (load_use) begin
                stall_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
                lu_stall     = 1'b1;
            end else if (jmp_taken && id_valid) begin
                flush_if_id  = 1'b1;
            end
        end
    end

    // A jump flushes IF_ID but the jump itself still moves on to EX.
    assign id_adv = id_valid & ~stall_if_id & ~bubble_id_ex;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (id_adv && id_is_hlt) begin
                    state_d = StDrain;
                    cnt_d   = CW'(NUM_STAGES);
                end
            end
            StDrain: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == '0) state_d = StHalted;
            end
            StHalted: ;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            cnt_q        <= '0;
            sb_valid_q   <= '0;
            sb_we_q      <= '0;
            sb_load_q    <= '0;
            for (int s = 0; s < int'(NUM_STAGES); s++) sb_dst_q[s] <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rs_used_q <= 1'b0;
            ex_rt_used_q <= 1'b0;
        end else if (!freeze_c) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int s = 1; s < int'(NUM_STAGES); s++) begin
                sb_valid_q[s] <= sb_valid_q[s-1];
                sb_we_q[s]    <= sb_we_q[s-1];
                sb_load_q[s]  <= sb_load_q[s-1];
                sb_dst_q[s]   <= sb_dst_q[s-1];
            end
            sb_valid_q[0] <= id_adv;
            sb_we_q[0]    <= id_adv & id_we_rf;
            sb_load_q[0]  <= id_adv & id_is_load;
            sb_dst_q[0]   <= id_adv ? id_dst_addr : '0;
            ex_rs_q       <= id_adv ? id_rs_addr : '0;
            ex_rt_q       <= id_adv ? id_rt_addr : '0;
            ex_rs_used_q  <= id_adv & id_rs_used;
            ex_rt_used_q  <= id_adv & id_rt_used;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (lu_stall && stall_cnt != 16'hffff) stall_cnt <= stall_cnt + 16'd1;
            if (flush_if_id && flush_cnt != 16'hffff) flush_cnt <= flush_cnt + 16'd1;
        end
    end
`else
    logic unused_lu_stall;
    assign unused_lu_stall = lu_stall;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a rule-level model of the pipeline.
module tb_pipe_hazard_ctrl;

    localparam int AW = 4;
    localparam int NS = 3;
    localparam int LS = 1;
    localparam int FW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_rs_used, id_rt_used, id_we_rf, id_is_load, id_is_hlt;
    logic [AW-1:0] id_rs_addr, id_rt_addr, id_dst_addr;
    logic          jmp_taken, br_taken, mem_busy;
    logic          stall_if_id, bubble_id_ex, flush_if_id, freeze, hlt;
    logic [FW-1:0] fwd_a, fwd_b;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0]   stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_AW(AW), .NUM_STAGES(NS), .LOAD_STAGE(LS), .FW_W(FW)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
        .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used), .id_we_rf(id_we_rf),
        .id_dst_addr(id_dst_addr), .id_is_load(id_is_load), .id_is_hlt(id_is_hlt),
        .jmp_taken(jmp_taken), .br_taken(br_taken), .mem_busy(mem_busy),
`ifdef HAZ_PERF_CNT_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
        .freeze(freeze), .fwd_a(fwd_a), .fwd_b(fwd_b), .hlt(hlt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: an in-flight instruction list indexed by stage, plus a halt mode.
    typedef struct {
        bit v; bit we; bit ld; int dst;
        bit rsu; bit rtu; int rs; int rt;
    } ins_t;

    ins_t pipe [NS];
    int   mode;        // 0 running, 1 draining, 2 halted
    int   drain_left;
    int   halted_cycles;
    int   p_stall_cnt, p_flush_cnt;

    bit e_stall, e_bub, e_flush, e_frz, e_hlt, e_lu_stall;
    int e_fa, e_fb;

    function automatic int fwd_for(input bit used, input int r);
        int sel = 0;
        if (used && r != 0)
            for (int s = NS - 1; s >= 1; s--)
                if (pipe[s].v && pipe[s].we && pipe[s].dst == r) sel = s;
        return sel;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) pipe[s] = '{default: 0};
        mode = 0;
        drain_left = 0;
        p_stall_cnt = 0;
        p_flush_cnt = 0;
    endtask

    task automatic model_outputs();
        bit hazard = 0;
        for (int s = 0; s < LS; s++)
            if (pipe[s].v && pipe[s].we && pipe[s].ld) begin
                if (id_rs_used && id_rs_addr != 0 && int'(id_rs_addr) == pipe[s].dst) hazard = 1;
                if (id_rt_used && id_rt_addr != 0 && int'(id_rt_addr) == pipe[s].dst) hazard = 1;
            end
        hazard = hazard && id_valid;
        e_stall = 0; e_bub = 0; e_flush = 0; e_lu_stall = 0;
        e_frz = !rst && (mem_busy || mode == 2);
        e_hlt = !rst && mode == 2;
        e_fa = rst ? 0 : fwd_for(pipe[0].rsu, pipe[0].rs);
        e_fb = rst ? 0 : fwd_for(pipe[0].rtu, pipe[0].rt);
        if (!rst && !e_frz) begin
            if (mode == 1) begin e_stall = 1; e_bub = 1; end
            else if (br_taken) begin e_flush = 1; e_bub = 1; end
            else if (hazard) begin e_stall = 1; e_bub = 1; e_lu_stall = 1; end
            else if (jmp_taken && id_valid) e_flush = 1;
        end
    endtask

    task automatic model_step();
        bit adv;
        if (rst) begin
            model_reset();
            return;
        end
        if (e_lu_stall && p_stall_cnt < 65535) p_stall_cnt++;
        if (e_flush && p_flush_cnt < 65535) p_flush_cnt++;
        if (e_frz) return;
        adv = id_valid && !e_stall && !e_bub;
        for (int s = NS - 1; s >= 1; s--) pipe[s] = pipe[s-1];
        pipe[0] = '{default: 0};
        if (adv) pipe[0] = '{v: 1, we: id_we_rf, ld: id_is_load, dst: int'(id_dst_addr),
                              rsu: id_rs_used, rtu: id_rt_used,
                              rs: int'(id_rs_addr), rt: int'(id_rt_addr)};
        if (mode == 0 && adv && id_is_hlt) begin
            mode = 1;
            drain_left = NS;
        end else if (mode == 1) begin
            drain_left--;
            if (drain_left == 0) mode = 2;
        end
    endtask

    task automatic compare_all();
        check_eq("stall_if_id", 32'(stall_if_id), 32'(e_stall));
        check_eq("bubble_id_ex", 32'(bubble_id_ex), 32'(e_bub));
        check_eq("flush_if_id", 32'(flush_if_id), 32'(e_flush));
        check_eq("freeze", 32'(freeze), 32'(e_frz));
        check_eq("fwd_a", 32'(fwd_a), 32'(e_fa));
        check_eq("fwd_b", 32'(fwd_b), 32'(e_fb));
        check_eq("hlt", 32'(hlt), 32'(e_hlt));
`ifdef HAZ_PERF_CNT_EN
        check_eq("stall_cnt", 32'(stall_cnt), 32'(p_stall_cnt));
        check_eq("flush_cnt", 32'(flush_cnt), 32'(p_flush_cnt));
`endif
    endtask

    task automatic drive_random();
        rst         = ($urandom % 300 == 0) || halted_cycles > 4;
        id_valid    = ($urandom % 8) != 0;
        id_rs_addr  = AW'($urandom_range(0, 7));
        id_rt_addr  = AW'($urandom_range(0, 7));
        id_dst_addr = AW'($urandom_range(0, 7));
        id_rs_used  = ($urandom % 4) != 0;
        id_rt_used  = ($urandom % 4) != 0;
        id_we_rf    = ($urandom % 4) != 0;
        id_is_load  = ($urandom % 3) == 0;
        id_is_hlt   = ($urandom % 48) == 0;
        jmp_taken   = ($urandom % 10) == 0;
        br_taken    = ($urandom % 10) == 0;
        mem_busy    = ($urandom % 6) == 0;
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_dst_addr = 0;
        id_rs_used = 0; id_rt_used = 0; id_we_rf = 0; id_is_load = 0; id_is_hlt = 0;
        jmp_taken = 0; br_taken = 0; mem_busy = 1;
        model_reset();
        halted_cycles = 0;
        // Reset cycles with busy memory asserted: every output must still read 0.
        repeat (2) begin
            @(negedge clk);
            #1;
            model_outputs();
            compare_all();
            @(posedge clk);
            model_step();
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            drive_random();
            #1;
            model_outputs();
            compare_all();
            @(posedge clk);
            model_step();
            halted_cycles = (mode == 2) ? halted_cycles + 1 : 0;
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
